// File: rtl/mult_pkg.sv
// Shared state encoding for the shift-and-add multiplier controller.
package mult_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        TEST  = 3'd2,
        ADD   = 3'd3,
        SHIFT = 3'd4,
        DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/mult_ctrl.sv
// Moore controller sequencing a shift-and-add multiplier datapath
// (A shifts left, B shifts right, P accumulates).
module mult_ctrl
    import mult_pkg::*;
#(
    parameter int NBITS = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         b0,
    input  logic                         z,
    output logic                         ctrlA,
    output logic                         ctrlB,
    output logic                         ldA,
    output logic                         ldB,
    output logic                         Psel,
    output logic                         ldP,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(NBITS+1)-1:0]   count
);

    localparam int CW = $clog2(NBITS+1);
    localparam logic [CW-1:0] CMAX = CW'(NBITS);

    state_t        state, state_nx;
    logic [CW-1:0] count_nx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_nx;
            count <= count_nx;
        end
    end

    always_comb begin
        state_nx = state;
        count_nx = count;
        ctrlA    = 1'b0;
        ctrlB    = 1'b0;
        ldA      = 1'b0;
        ldB      = 1'b0;
        Psel     = 1'b0;
        ldP      = 1'b0;
        done     = 1'b0;
        busy     = (state != IDLE) && (state != DONE);

        case (state)
            IDLE: begin
                if (start) state_nx = LOAD;
            end
            LOAD: begin
                ldA      = 1'b1;
                ldB      = 1'b1;
                ldP      = 1'b1;
                count_nx = '0;
                state_nx = TEST;
            end
            TEST: begin
                // count limit bounds the loop even if z never rises
                if (z || (count == CMAX))
                    state_nx = DONE;
                else if (b0)
                    state_nx = ADD;
                else
                    state_nx = SHIFT;
            end
            ADD: begin
                Psel     = 1'b1;
                ldP      = 1'b1;
                state_nx = SHIFT;
            end
            SHIFT: begin
                ctrlA    = 1'b1;
                ctrlB    = 1'b1;
                ldA      = 1'b1;
                ldB      = 1'b1;
                if (count != CMAX) count_nx = count + CW'(1);
                state_nx = TEST;
            end
            DONE: begin
                done = 1'b1;
                if (!start) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule
